// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR period monitor.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    COUNT
  } lfsr_mon_state_t;

  function automatic int unsigned lfsr_max_period(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_match_counter.sv
// Reference register, recurrence comparator and sample counter for the period monitor.
module lfsr_match_counter
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             advance,
  input  logic [WIDTH-1:0] sample_in,
  output logic             match,
  output logic             timeout,
  output logic [CNT_W-1:0] next_count
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1) << WIDTH;

  logic [WIDTH-1:0] ref_state;
  logic [CNT_W-1:0] count_q;

  assign next_count = count_q + CNT_W'(1);
  assign match      = (sample_in == ref_state);
  assign timeout    = (next_count == FULL_COUNT);

  // Counter only advances on non-terminal samples, so it can never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_state <= '0;
      count_q   <= '0;
    end else if (capture) begin
      ref_state <= sample_in;
      count_q   <= '0;
    end else if (advance && !match && !timeout) begin
      count_q <= next_count;
    end
  end

endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state stream and flags lock-up/non-repeat faults.
// Optional zero-state abort enabled by defining LFSR_MON_ZERO_CHECK_EN.
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             busy,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             is_maximal,
  output logic             error_zero,
  output logic             error_timeout
);

  localparam logic [CNT_W-1:0] MAX_PERIOD = CNT_W'(lfsr_max_period(WIDTH));

  lfsr_mon_state_t  state;
  logic             match;
  logic             timeout;
  logic [CNT_W-1:0] next_count;

  lfsr_match_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .capture   (state == CAPTURE && sample_valid),
    .advance   (state == COUNT && sample_valid),
    .sample_in (sample_in),
    .match     (match),
    .timeout   (timeout),
    .next_count(next_count)
  );

`ifdef LFSR_MON_ZERO_CHECK_EN
  logic is_zero;
  assign is_zero = (sample_in == '0);
`else
  assign error_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      period_out    <= '0;
      period_valid  <= 1'b0;
      is_maximal    <= 1'b0;
      error_timeout <= 1'b0;
`ifdef LFSR_MON_ZERO_CHECK_EN
      error_zero    <= 1'b0;
`endif
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= CAPTURE;
            busy          <= 1'b1;
            error_timeout <= 1'b0;
`ifdef LFSR_MON_ZERO_CHECK_EN
            error_zero    <= 1'b0;
`endif
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
`ifdef LFSR_MON_ZERO_CHECK_EN
            if (is_zero) begin
              error_zero <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else
`endif
            state <= COUNT;
          end
        end
        COUNT: begin
          if (sample_valid) begin
`ifdef LFSR_MON_ZERO_CHECK_EN
            if (is_zero) begin
              error_zero <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else
`endif
            // A match on the 2^WIDTH-th sample wins over the timeout.
            if (match) begin
              period_out   <= next_count;
              period_valid <= 1'b1;
              is_maximal   <= (next_count == MAX_PERIOD);
              state        <= IDLE;
              busy         <= 1'b0;
            end else if (timeout) begin
              error_timeout <= 1'b1;
              state         <= IDLE;
              busy          <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Self-checking bench for lfsr_period_monitor: directed vector table, corner sequences, random streams.
module tb_lfsr_period_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       busy;
  logic [9:0] period_out;
  logic       period_valid;
  logic       is_maximal;
  logic       error_zero;
  logic       error_timeout;

  lfsr_period_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .busy         (busy),
    .period_out   (period_out),
    .period_valid (period_valid),
    .is_maximal   (is_maximal),
    .error_zero   (error_zero),
    .error_timeout(error_timeout)
  );

  initial forever #5 clk = ~clk;

  int pass_cnt = 0;
  int total = 0;

  logic [8:0] q_d[$];
  bit         q_v[$];
  bit         q_s[$];

  int exp_po = 0;
  bit exp_im = 1'b0;

  typedef struct {
    int    kind;
    int    len;
    int    exp_per;
    bit    exp_max;
    bit    exp_to;
    bit    exp_zero;
    int    exp_end;
    string name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [8:0] lfsr_next(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  function automatic vec_t mk(input int kind, input int len, input int per, input bit mx,
                              input bit to, input bit z, input int e, input string name);
    vec_t v;
    v.kind = kind; v.len = len; v.exp_per = per; v.exp_max = mx;
    v.exp_to = to; v.exp_zero = z; v.exp_end = e; v.name = name;
    return v;
  endfunction

  // Reference: scan the stream for the first valid sample R and find when R recurs.
  function automatic void model(output int per, output bit to, output bit z, output int endk);
    int r;
    int n;
    r = -1; n = 0; per = -1; to = 1'b0; z = 1'b0; endk = -1;
    for (int k = 0; k < q_d.size(); k++) begin
      if (!q_v[k]) continue;
`ifdef LFSR_MON_ZERO_CHECK_EN
      if (q_d[k] == 9'd0) begin z = 1'b1; endk = k; return; end
`endif
      if (r < 0) begin r = int'(q_d[k]); continue; end
      n++;
      if (int'(q_d[k]) == r) begin per = n; endk = k; return; end
      if (n == 512) begin to = 1'b1; endk = k; return; end
    end
  endfunction

  task automatic do_start(input string name);
    start = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " busy after start"}, busy, 1);
    check({name, " timeout cleared"}, error_timeout, 0);
    check({name, " zero cleared"}, error_zero, 0);
  endtask

  task automatic play(output int pv_cnt, output int end_k);
    pv_cnt = 0;
    end_k = -1;
    for (int k = 0; k < q_d.size(); k++) begin
      sample_in = q_d[k];
      sample_valid = q_v[k];
      start = q_s[k];
      @(posedge clk); #1;
      if (period_valid) pv_cnt++;
      if (!busy && end_k < 0) end_k = k;
    end
    sample_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic clear_q();
    q_d.delete(); q_v.delete(); q_s.delete();
  endtask

  task automatic check_result(input string name, input int pv_cnt, input int end_k,
                              input int per, input bit to, input bit z, input int endk);
    if (per >= 0) begin
      exp_po = per;
      exp_im = (per == 511);
    end
    check({name, " pv pulses"}, pv_cnt, (per >= 0) ? 1 : 0);
    check({name, " end cycle"}, end_k, endk);
    check({name, " period_out"}, period_out, exp_po);
    check({name, " is_maximal"}, is_maximal, exp_im);
    check({name, " error_timeout"}, error_timeout, to);
    check({name, " error_zero"}, error_zero, z);
    check({name, " busy low"}, busy, 0);
  endtask

  initial begin
    int pv_cnt;
    int end_k;
    logic [8:0] s;

    vecs[0] = mk(0, 520, 511, 1'b1, 1'b0, 1'b0, 511, "lfsr");
    vecs[1] = mk(1, 4, 1, 1'b0, 1'b0, 1'b0, 1, "const5");
    vecs[3] = mk(3, 520, -1, 1'b0, 1'b1, 1'b0, 512, "timeout");
`ifdef LFSR_MON_ZERO_CHECK_EN
    vecs[2] = mk(2, 520, -1, 1'b0, 1'b0, 1'b1, 509, "upcount");
    vecs[4] = mk(4, 8, -1, 1'b0, 1'b0, 1'b1, 4, "zero4");
`else
    vecs[2] = mk(2, 520, 512, 1'b0, 1'b0, 1'b0, 512, "upcount");
    vecs[4] = mk(4, 8, 5, 1'b0, 1'b0, 1'b0, 5, "zero4");
`endif

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset period_out", period_out, 0);
    check("reset period_valid", period_valid, 0);
    check("reset is_maximal", is_maximal, 0);
    check("reset error_zero", error_zero, 0);
    check("reset error_timeout", error_timeout, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_start(vecs[i].name);
      clear_q();
      s = 9'd1;
      for (int k = 0; k < vecs[i].len; k++) begin
        case (vecs[i].kind)
          0: begin q_d.push_back(s); s = lfsr_next(s); end
          1: q_d.push_back(9'd5);
          2: q_d.push_back(9'((3 + k) % 512));
          3: q_d.push_back((k == 0) ? 9'd3 : 9'd7);
          default: q_d.push_back((k == 4) ? 9'd0 : (k < 4) ? 9'(10 + k) : 9'd10);
        endcase
        q_v.push_back(1'b1);
        // start arriving together with the terminating sample must be ignored
        q_s.push_back(vecs[i].kind == 1 && k == 1);
      end
      play(pv_cnt, end_k);
      check_result(vecs[i].name, pv_cnt, end_k, vecs[i].exp_per, vecs[i].exp_to,
                   vecs[i].exp_zero, vecs[i].exp_end);
    end

    // Restart after the zero run: flags clear on entry, then a full LFSR period.
    do_start("restart");
    clear_q();
    s = 9'd1;
    for (int k = 0; k < 520; k++) begin
      q_d.push_back(s); q_v.push_back(1'b1); q_s.push_back(1'b0);
      s = lfsr_next(s);
    end
    play(pv_cnt, end_k);
    check_result("restart", pv_cnt, end_k, 511, 1'b0, 1'b0, 511);

    // Reset at count 100 of an LFSR run.
    do_start("abort");
    clear_q();
    s = 9'd1;
    for (int k = 0; k < 101; k++) begin
      q_d.push_back(s); q_v.push_back(1'b1); q_s.push_back(1'b0);
      s = lfsr_next(s);
    end
    play(pv_cnt, end_k);
    check("abort still busy", busy, 1);
    reset = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sample_valid = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset period_out", period_out, 0);
    check("midreset period_valid", period_valid, 0);
    check("midreset is_maximal", is_maximal, 0);
    check("midreset error_timeout", error_timeout, 0);
    check("midreset error_zero", error_zero, 0);
    exp_po = 0;
    exp_im = 1'b0;

    // Gapped run, one valid sample every third cycle, with a start pulse mid-run.
    do_start("gapped");
    clear_q();
    s = 9'd1;
    for (int k = 0; k < 1540; k++) begin
      if (k % 3 == 0) begin
        q_d.push_back(s); q_v.push_back(1'b1);
        s = lfsr_next(s);
      end else begin
        q_d.push_back(9'd0); q_v.push_back(1'b0);
      end
      q_s.push_back(k == 300);
    end
    play(pv_cnt, end_k);
    check_result("gapped", pv_cnt, end_k, 511, 1'b0, 1'b0, 1533);

    // Random streams against the reference model.
    for (int r = 0; r < 20; r++) begin
      int per;
      int endk;
      bit to;
      bit z;
      do begin
        clear_q();
        for (int k = 0; k < 900; k++) begin
          q_d.push_back((r % 2 == 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, 511)));
          q_v.push_back($urandom_range(0, 9) < 7);
          q_s.push_back(1'b0);
        end
        model(per, to, z, endk);
      end while (endk < 0);
      for (int k = 0; k <= endk; k++)
        if ($urandom_range(0, 24) == 0) q_s[k] = 1'b1;
      do_start($sformatf("rand%0d", r));
      play(pv_cnt, end_k);
      check_result($sformatf("rand%0d", r), pv_cnt, end_k, per, to, z, endk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
